// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer for the single data-memory port: CPU load/store
// path (master 0) and an external requester (master 1), one access at a time.
module dmem_arbiter #(
   parameter int RD_LATENCY   = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_wr_en,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [1:0]  cpu_store_size,
   input  logic [1:0]  cpu_load_size,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ack,
   output logic        cpu_stall,
   input  logic        ext_req,
   input  logic        ext_wr_en,
   input  logic [31:0] ext_addr,
   input  logic [31:0] ext_wdata,
   input  logic [1:0]  ext_store_size,
   input  logic [1:0]  ext_load_size,
   output logic [31:0] ext_rdata,
   output logic        ext_ack,
   output logic        d_wr_en,
   output logic [31:0] dAddr,
   output logic [31:0] dWdata,
   output logic [1:0]  store_size,
   output logic [1:0]  load_size,
   input  logic [31:0] dRdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   state_e      state_q, state_d;
   logic        win_q, win_d;       // 0 = cpu, 1 = ext
   logic        wr_q, wr_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  ssize_q, ssize_d;
   logic [1:0]  lsize_q, lsize_d;
   logic [2:0]  lat_q, lat_d;
   logic [3:0]  starve_q, starve_d;
   logic [31:0] cpu_rdata_q, cpu_rdata_d;
   logic [31:0] ext_rdata_q, ext_rdata_d;
   logic        grant_ext;

   // ext only beats a requesting cpu once it has lost STARVE_LIMIT times in a row
   assign grant_ext = ext_req & (~cpu_req | (starve_q == 4'(STARVE_LIMIT)));

   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      ssize_d     = ssize_q;
      lsize_d     = lsize_q;
      lat_d       = lat_q;
      starve_d    = starve_q;
      cpu_rdata_d = cpu_rdata_q;
      ext_rdata_d = ext_rdata_q;
      case (state_q)
         IDLE: begin
            if (!ext_req || grant_ext)
               starve_d = 4'd0;
            else if (starve_q != 4'(STARVE_LIMIT))
               starve_d = starve_q + 4'd1;
            if (cpu_req || ext_req) begin
               win_d   = grant_ext;
               wr_d    = grant_ext ? ext_wr_en      : cpu_wr_en;
               addr_d  = grant_ext ? ext_addr       : cpu_addr;
               wdata_d = grant_ext ? ext_wdata      : cpu_wdata;
               ssize_d = grant_ext ? ext_store_size : cpu_store_size;
               lsize_d = grant_ext ? ext_load_size  : cpu_load_size;
               lat_d   = 3'd0;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (wr_q || lat_q == 3'(RD_LATENCY)) begin
               state_d = RESP;
               if (!wr_q) begin
                  if (win_q) ext_rdata_d = dRdata;
                  else       cpu_rdata_d = dRdata;
               end
            end else begin
               lat_d = lat_q + 3'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         win_q       <= 1'b0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         ssize_q     <= '0;
         lsize_q     <= '0;
         lat_q       <= '0;
         starve_q    <= '0;
         cpu_rdata_q <= '0;
         ext_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         win_q       <= win_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         ssize_q     <= ssize_d;
         lsize_q     <= lsize_d;
         lat_q       <= lat_d;
         starve_q    <= starve_d;
         cpu_rdata_q <= cpu_rdata_d;
         ext_rdata_q <= ext_rdata_d;
      end
   end

   // write strobe only on the first ACCESS cycle so a multi-cycle slot never double-writes
   assign d_wr_en    = (state_q == ACCESS) && (lat_q == 3'd0) && wr_q;
   assign dAddr      = addr_q;
   assign dWdata     = wdata_q;
   assign store_size = ssize_q;
   assign load_size  = lsize_q;
   assign cpu_ack    = (state_q == RESP) && !win_q;
   assign ext_ack    = (state_q == RESP) && win_q;
   assign cpu_stall  = cpu_req & ~cpu_ack;
   assign cpu_rdata  = cpu_rdata_q;
   assign ext_rdata  = ext_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (RD_LATENCY 1, 0, 3) on shared
// stimulus with a latency-accurate memory model; instance 0 owns the memory.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_wr_en, ext_req, ext_wr_en;
   logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
   logic [1:0]  cpu_store_size, cpu_load_size, ext_store_size, ext_load_size;

   logic        cpu_ack_a [3];
   logic        ext_ack_a [3];
   logic        cpu_stall_a [3];
   logic        d_wr_en_a [3];
   logic [31:0] cpu_rdata_a [3];
   logic [31:0] ext_rdata_a [3];
   logic [31:0] dAddr_a [3];
   logic [31:0] dWdata_a [3];
   logic [31:0] dRdata_a [3];
   logic [1:0]  ss_a [3];
   logic [1:0]  ls_a [3];
   logic [31:0] mem [0:255];

   typedef struct {
      bit          ext;
      int          cyc;
      logic [31:0] rdata;
   } exp_t;
   exp_t sbq[$];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 1 : (g == 1) ? 0 : 3;
      logic [31:0] pipe [0:3];
      dmem_arbiter #(.RD_LATENCY(LAT), .STARVE_LIMIT(4)) u_dut (
         .clk(clk), .rst(rst),
         .cpu_req(cpu_req), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
         .cpu_wdata(cpu_wdata), .cpu_store_size(cpu_store_size),
         .cpu_load_size(cpu_load_size), .cpu_rdata(cpu_rdata_a[g]),
         .cpu_ack(cpu_ack_a[g]), .cpu_stall(cpu_stall_a[g]),
         .ext_req(ext_req), .ext_wr_en(ext_wr_en), .ext_addr(ext_addr),
         .ext_wdata(ext_wdata), .ext_store_size(ext_store_size),
         .ext_load_size(ext_load_size), .ext_rdata(ext_rdata_a[g]),
         .ext_ack(ext_ack_a[g]), .d_wr_en(d_wr_en_a[g]), .dAddr(dAddr_a[g]),
         .dWdata(dWdata_a[g]), .store_size(ss_a[g]), .load_size(ls_a[g]),
         .dRdata(dRdata_a[g])
      );
      always @(posedge clk) begin
         pipe[0] <= mem[dAddr_a[g][9:2]];
         for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      end
      if (LAT == 0) begin : g_comb
         assign dRdata_a[g] = mem[dAddr_a[g][9:2]];
      end else begin : g_pipe
         assign dRdata_a[g] = pipe[LAT-1];
      end
   end

   always @(posedge clk)
      if (d_wr_en_a[0]) mem[dAddr_a[0][9:2]] <= dWdata_a[0];

   task automatic set_cpu(input logic req, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] ss, input logic [1:0] ls);
      cpu_req = req; cpu_wr_en = wr; cpu_addr = a; cpu_wdata = d;
      cpu_store_size = ss; cpu_load_size = ls;
   endtask

   task automatic set_ext(input logic req, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] ss, input logic [1:0] ls);
      ext_req = req; ext_wr_en = wr; ext_addr = a; ext_wdata = d;
      ext_store_size = ss; ext_load_size = ls;
   endtask

   task automatic do_reset();
      cpu_req = 1'b0; ext_req = 1'b0; rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
   endtask

   // Called just after a rising edge (cycle 0); returns at the falling edge of the ack cycle.
   task automatic wait_ack(input int inst, output int cyc, output bit got, output bit ex);
      cyc = 0; got = 1'b0; ex = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cpu_ack_a[inst] || ext_ack_a[inst]) begin
            got = 1'b1; ex = ext_ack_a[inst];
            return;
         end
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_cpu(1'b1, 1'b0, 32'h0, 32'h0, 2'd0, 2'd0);
      set_ext(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 2'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({cpu_ack_a[0], ext_ack_a[0], d_wr_en_a[0], dAddr_a[0], dWdata_a[0], ss_a[0],
           ls_a[0], cpu_rdata_a[0], ext_rdata_a[0]} !== '0) begin
         bad++; $display("FAIL reset_outputs: got nonzero dAddr=%h dWdata=%h, want all 0",
                         dAddr_a[0], dWdata_a[0]);
      end
      total++;
      if (cpu_stall_a[0] !== 1'b1) begin
         bad++; $display("FAIL reset_stall_hi: got %b want 1", cpu_stall_a[0]);
      end
      cpu_req = 1'b0; #1;
      total++;
      if (cpu_stall_a[0] !== 1'b0) begin
         bad++; $display("FAIL reset_stall_lo: got %b want 0", cpu_stall_a[0]);
      end
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_write();
      exp_t e;
      set_cpu(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 2'd0);
      sbq.push_back('{1'b0, 2, 32'h0});
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++;
         if (d_wr_en_a[0] !== (c == 1)) begin
            bad++; $display("FAIL wr_strobe c%0d: got %b want %b", c, d_wr_en_a[0], c == 1);
         end
         if (c == 1) begin
            total++;
            if (dAddr_a[0] !== 32'h10 || dWdata_a[0] !== 32'hDEADBEEF || ss_a[0] !== 2'd2) begin
               bad++; $display("FAIL wr_port: got %h/%h/%0d want 10/deadbeef/2",
                               dAddr_a[0], dWdata_a[0], ss_a[0]);
            end
         end
         if (c < 3) begin
            total++;
            if (cpu_stall_a[0] !== (c < 2)) begin
               bad++; $display("FAIL wr_stall c%0d: got %b want %b", c, cpu_stall_a[0], c < 2);
            end
         end
         if (cpu_ack_a[0] || ext_ack_a[0]) begin
            e = sbq.pop_front();
            total++;
            if (c != e.cyc || ext_ack_a[0] !== e.ext) begin
               bad++; $display("FAIL wr_ack: got cyc %0d ext %b want cyc %0d ext %b",
                               c, ext_ack_a[0], e.cyc, e.ext);
            end
         end
         @(posedge clk); #1;
         if (c == 2) cpu_req = 1'b0;
      end
      total++;
      if (sbq.size() != 0 || cpu_rdata_a[0] !== 32'h0) begin
         bad++; $display("FAIL wr_done: pending %0d rdata %h want 0 pending, rdata 0",
                         sbq.size(), cpu_rdata_a[0]);
         sbq.delete();
      end
   endtask

   task automatic test_read();
      exp_t e; int c; bit got, ex;
      // cpu load
      set_cpu(1'b1, 1'b0, 32'h10, 32'h0, 2'd0, 2'd2);
      sbq.push_back('{1'b0, 3, 32'hDEADBEEF});
      wait_ack(0, c, got, ex);
      e = sbq.pop_front();
      total++;
      if (!got || c != e.cyc || ex != e.ext || cpu_rdata_a[0] !== e.rdata) begin
         bad++; $display("FAIL cpu_read: got ack %b cyc %0d data %h want cyc %0d data %h",
                         got, c, cpu_rdata_a[0], e.cyc, e.rdata);
      end
      @(posedge clk); #1 cpu_req = 1'b0;
      // ext write then ext read
      set_ext(1'b1, 1'b1, 32'h20, 32'h12345678, 2'd2, 2'd0);
      sbq.push_back('{1'b1, 2, 32'h0});
      wait_ack(0, c, got, ex);
      e = sbq.pop_front();
      total++;
      if (!got || c != e.cyc || ex != e.ext) begin
         bad++; $display("FAIL ext_write: got ack %b cyc %0d ext %b want cyc %0d ext 1",
                         got, c, ex, e.cyc);
      end
      @(posedge clk); #1 ext_req = 1'b0;
      set_ext(1'b1, 1'b0, 32'h20, 32'h0, 2'd0, 2'd2);
      sbq.push_back('{1'b1, 3, 32'h12345678});
      wait_ack(0, c, got, ex);
      e = sbq.pop_front();
      total++;
      if (!got || c != e.cyc || ex != e.ext || ext_rdata_a[0] !== e.rdata) begin
         bad++; $display("FAIL ext_read: got ack %b cyc %0d data %h want cyc %0d data %h",
                         got, c, ext_rdata_a[0], e.cyc, e.rdata);
      end
      total++;
      if (cpu_rdata_a[0] !== 32'hDEADBEEF) begin
         bad++; $display("FAIL cpu_rdata_hold: got %h want deadbeef", cpu_rdata_a[0]);
      end
      @(posedge clk); #1 ext_req = 1'b0;
   endtask

   task automatic test_starve();
      exp_t e; int c; bit got, ex;
      logic [31:0] rd;
      set_cpu(1'b1, 1'b0, 32'h10, 32'h0, 2'd0, 2'd2);
      set_ext(1'b1, 1'b0, 32'h20, 32'h0, 2'd0, 2'd2);
      for (int k = 0; k < 6; k++)
         sbq.push_back('{k == 4, 3, (k == 4) ? 32'h12345678 : 32'hDEADBEEF});
      for (int k = 0; k < 6; k++) begin
         wait_ack(0, c, got, ex);
         rd = ex ? ext_rdata_a[0] : cpu_rdata_a[0];
         e = sbq.pop_front();
         total++;
         if (!got || c != e.cyc || ex != e.ext || rd !== e.rdata) begin
            bad++; $display("FAIL starve_grant%0d: got ack %b ext %b cyc %0d data %h want ext %b cyc %0d data %h",
                            k, got, ex, c, rd, e.ext, e.cyc, e.rdata);
         end
         @(posedge clk); #1;
      end
      cpu_req = 1'b0; ext_req = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_latency();
      exp_t e;
      int ack_c [3];
      logic [31:0] rd [3];
      do_reset();
      for (int i = 0; i < 3; i++) ack_c[i] = -1;
      sbq.push_back('{1'b0, 3, 32'hDEADBEEF});
      sbq.push_back('{1'b0, 2, 32'hDEADBEEF});
      sbq.push_back('{1'b0, 5, 32'hDEADBEEF});
      set_cpu(1'b1, 1'b0, 32'h10, 32'h0, 2'd0, 2'd2);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++)
            if (cpu_ack_a[i] && ack_c[i] < 0) begin
               ack_c[i] = c; rd[i] = cpu_rdata_a[i];
            end
         @(posedge clk); #1;
         if (c == 5) cpu_req = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
         e = sbq.pop_front();
         total++;
         if (ack_c[i] != e.cyc || rd[i] !== e.rdata) begin
            bad++; $display("FAIL latency_inst%0d: got cyc %0d data %h want cyc %0d data %h",
                            i, ack_c[i], rd[i], e.cyc, e.rdata);
         end
      end
   endtask

   task automatic test_ext_mid();
      exp_t e;
      do_reset();
      set_ext(1'b1, 1'b0, 32'h20, 32'h0, 2'd0, 2'd2);
      sbq.push_back('{1'b1, 3, 32'h12345678});
      sbq.push_back('{1'b0, 7, 32'hDEADBEEF});
      for (int c = 0; c < 12; c++) begin
         if (c == 2) set_cpu(1'b1, 1'b0, 32'h10, 32'h0, 2'd0, 2'd2);
         if (c == 4) ext_req = 1'b0;
         if (c == 8) cpu_req = 1'b0;
         @(negedge clk);
         if (c == 1 || c == 2) begin
            total++;
            if (dAddr_a[0] !== 32'h20) begin
               bad++; $display("FAIL mid_addr c%0d: got %h want 20", c, dAddr_a[0]);
            end
         end
         if (c >= 2 && c < 7) begin
            total++;
            if (cpu_stall_a[0] !== 1'b1) begin
               bad++; $display("FAIL mid_stall c%0d: got %b want 1", c, cpu_stall_a[0]);
            end
         end
         if (cpu_ack_a[0] || ext_ack_a[0]) begin
            if (sbq.size() == 0) begin
               total++; bad++;
               $display("FAIL mid_extra_ack c%0d: got ack want none", c);
            end else begin
               e = sbq.pop_front();
               total++;
               if (c != e.cyc || ext_ack_a[0] !== e.ext ||
                   (e.ext ? ext_rdata_a[0] : cpu_rdata_a[0]) !== e.rdata) begin
                  bad++; $display("FAIL mid_ack c%0d: got ext %b want cyc %0d ext %b data %h",
                                  c, ext_ack_a[0], e.cyc, e.ext, e.rdata);
               end
            end
         end
         @(posedge clk); #1;
      end
      total++;
      if (sbq.size() != 0) begin
         bad++; $display("FAIL mid_missing: got %0d acks pending want 0", sbq.size());
         sbq.delete();
      end
   endtask

   task automatic test_reset_mid();
      exp_t e; int c; bit got, ex;
      int acks = 0;
      set_cpu(1'b1, 1'b0, 32'h10, 32'h0, 2'd0, 2'd2);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      total++;
      if ({cpu_ack_a[0], ext_ack_a[0], d_wr_en_a[0], dAddr_a[0], dWdata_a[0], ss_a[0],
           ls_a[0], cpu_rdata_a[0], ext_rdata_a[0]} !== '0) begin
         bad++; $display("FAIL rstmid_outputs: got dAddr=%h ls=%0d rdata=%h want all 0",
                         dAddr_a[0], ls_a[0], cpu_rdata_a[0]);
      end
      cpu_req = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (cpu_ack_a[0] || ext_ack_a[0]) acks++;
         @(posedge clk); #1;
         if (k == 1) rst = 1'b0;
      end
      total++;
      if (acks != 0) begin
         bad++; $display("FAIL rstmid_no_ack: got %0d acks want 0", acks);
      end
      set_cpu(1'b1, 1'b0, 32'h10, 32'h0, 2'd0, 2'd2);
      sbq.push_back('{1'b0, 3, 32'hDEADBEEF});
      wait_ack(0, c, got, ex);
      e = sbq.pop_front();
      total++;
      if (!got || c != e.cyc || ex != e.ext || cpu_rdata_a[0] !== e.rdata) begin
         bad++; $display("FAIL rstmid_after: got ack %b cyc %0d data %h want cyc %0d data %h",
                         got, c, cpu_rdata_a[0], e.cyc, e.rdata);
      end
      @(posedge clk); #1 cpu_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_starve();
      test_latency();
      test_ext_mid();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion want finish");
      $fatal(1);
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter and sequencer for the single data-memory port: master 0 is the CPU core's load/store path, master 1 is an external requester (program loader / debug / DMA).
- Sits between cpu_core, the external requester and data_memory.
- Latches one request at a time, drives the memory port for a fixed number of cycles, and returns a one-cycle ack with registered read data.
- Stalls the CPU while its access is pending.

Parameters:
RD_LATENCY, 1, cycles from address presentation to valid dRdata (0 = combinational memory read); legal 0..7
STARVE_LIMIT, 4, consecutive lost arbitrations after which ext wins over cpu; legal 1..15

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_wr_en  in  1  1 = store, 0 = load
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data
cpu_store_size  in  2  store size code, passed through unchanged
cpu_load_size  in  2  load size code, passed through unchanged
cpu_rdata  out  32  load data, valid in the cpu_ack cycle and held until the next CPU read ack
cpu_ack  out  1  one-cycle completion pulse
cpu_stall  out  1  cpu_req & ~cpu_ack, combinational
ext_req, ext_wr_en, ext_addr, ext_wdata, ext_store_size, ext_load_size  in  1/1/32/32/2/2  same meaning as the cpu_* inputs
ext_rdata  out  32  same meaning as cpu_rdata
ext_ack  out  1  same meaning as cpu_ack
d_wr_en  out  1  memory write enable
dAddr  out  32  memory address
dWdata  out  32  memory write data
store_size  out  2  memory store size
load_size  out  2  memory load size
dRdata  in  32  memory read data

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE.
  - All outputs are 0, except cpu_stall, which follows cpu_req.
  - Starvation counter and latched registers are cleared.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If no req, stay in IDLE.
  - Otherwise choose a winner, latch its wr_en/addr/wdata/sizes, clear the latency counter, and go to ACCESS.
- Arbitration (evaluated only in IDLE):
  - Only one master requesting: that master wins.
  - Both requesting: cpu wins unless starve_cnt == STARVE_LIMIT, in which case ext wins.
- Starvation counter (starve_cnt):
  - Increments on each IDLE cycle where ext_req=1 and cpu wins.
  - Clears when ext is granted or when ext_req=0 in IDLE.
  - Saturates at STARVE_LIMIT.
- ACCESS:
  - dAddr, dWdata, store_size and load_size are driven from the latched registers.
  - d_wr_en equals the latched wr_en in the first ACCESS cycle only, 0 afterwards.
  - Write: done in the first ACCESS cycle.
  - Read: stays RD_LATENCY+1 cycles; on the last cycle, dRdata is captured into the winner's rdata register.
  - When done, go to RESP.
- RESP:
  - Winner's ack = 1 for exactly one cycle; memory d_wr_en = 0.
  - Always returns to IDLE; no grant is made in RESP.
  - The master must drop req, or present a new request, in the cycle after ack.
- Timing, request first seen in IDLE at cycle 0:
  - Write: d_wr_en at cycle 1, ack at cycle 2; next grant is possible at cycle 3.
  - Read: address driven at cycles 1..1+RD_LATENCY, ack and rdata at cycle 2+RD_LATENCY.
- Memory outputs in IDLE/RESP: d_wr_en = 0; dAddr/dWdata/sizes hold the last latched values.
- Request fields are sampled only at grant; changes while pending are ignored.
- The non-winner's req is simply held; it is never dropped by the arbiter.
- cpu_rdata/ext_rdata are unchanged by writes and by the other master's reads.
- Reset mid-ACCESS: the transaction is abandoned with no ack. A write already pulsed remains in memory.
- Sizes and addresses are passed through; no alignment checks.

Test Plan:
1. RD_LATENCY=1; cpu store addr 0x10, data 0xDEADBEEF, size word -> d_wr_en high in cycle 1 only, dAddr=0x10; cpu_ack in cycle 2; cpu_stall high cycles 0-1.
2. cpu load from 0x10, memory returns 0xDEADBEEF -> cpu_ack in cycle 3 with cpu_rdata=0xDEADBEEF; value held through later ext reads.
3. cpu_req and ext_req both held continuously, STARVE_LIMIT=4 -> grant order cpu, cpu, cpu, cpu, ext, cpu...; ext_ack after the 4th cpu_ack.
4. RD_LATENCY=0 and RD_LATENCY=3 reads -> ack at cycle 2 and cycle 5 respectively.
5. Ext read in progress, cpu_req rises mid-ACCESS -> ext completes undisturbed; cpu granted in the next IDLE; cpu_stall high throughout.
6. rst asserted in the 2nd ACCESS cycle of a read -> all outputs 0 immediately, no ack ever issued; the next request after rst release completes normally.
